// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Transmit half of the debug UART link. Bytes arrive over a
//                valid/ready handshake into a small FIFO. They are sent on the
//                idle-high line LSB first, CLKS_PER_BIT clocks per bit.
//                Frames go out back-to-back, with no idle gap when the FIFO
//                still holds data at the end of a stop bit.
//  Options     : `define UART_TX_PARITY_EN adds an even-parity bit after
//                bit 7 (8E1 frame). Without it the frame is 8N1.
//  Ports       : clock      - system clock
//                reset      - asynchronous, active-low reset
//                tx_data    - byte to send
//                tx_valid   - tx_data valid this cycle
//                tx_ready   - FIFO can accept a byte (count < FIFO_DEPTH)
//                uart_tx    - registered serial line output
//                tx_busy    - frame in progress or FIFO non-empty
//                fifo_count - bytes waiting in the FIFO (not the one on line)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [7:0]                       tx_data,
    input  logic                             tx_valid,
    output logic                             tx_ready,
    output logic                             uart_tx,
    output logic                             tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(FIFO_DEPTH + 1);
    localparam int c_BW = $clog2(CLKS_PER_BIT);

    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_FULL     = c_CW'(FIFO_DEPTH);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd4;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]      state_q,   state_d;
    logic [c_BW-1:0] cnt_q,     cnt_d;
    logic [2:0]      bit_q,     bit_d;
    logic [7:0]      shift_q,   shift_d;
    logic [c_AW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [c_AW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [c_CW-1:0] count_q,   count_d;
    logic            uart_tx_q, uart_tx_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic w_push;
    logic w_pop;
    logic w_bit_end;

    // tx_ready comes from the registered count only, so a push into a full
    // FIFO is refused even when a pop happens on the same edge.
    assign tx_ready   = (count_q < c_FULL);
    assign w_push     = tx_valid && tx_ready;
    assign w_bit_end  = (cnt_q == c_BIT_LAST);
    // A pop happens either from idle or on the final cycle of the stop bit.
    // The second case gives back-to-back frames.
    assign w_pop      = (count_q != '0) &&
                        ((state_q == c_IDLE) || ((state_q == c_STOP) && w_bit_end));

    assign tx_busy    = (state_q != c_IDLE) || (count_q != '0);
    assign fifo_count = count_q;
    assign uart_tx    = uart_tx_q;

    // ------------------------------------------------------------------
    // FIFO bookkeeping (power-of-two depth: pointers wrap naturally)
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CW'(1);
            2'b01:   count_d = count_q - c_CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;

        // The bit-time counter only runs while a frame is on the line.
        if (state_q != c_IDLE) begin
            cnt_d = w_bit_end ? '0 : (cnt_q + c_BW'(1));
        end

        case (state_q)
            c_IDLE: begin
                if (w_pop) begin
                    state_d = c_START;
                    shift_d = mem_q[rd_ptr_q];
                    cnt_d   = '0;
                end
            end
            c_START: begin
                if (w_bit_end) begin
                    state_d = c_DATA;
                    bit_d   = 3'd0;
                end
            end
            c_DATA: begin
                if (w_bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = c_PARITY;
`else
                        state_d = c_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            c_PARITY: begin
                if (w_bit_end) begin
                    state_d = c_STOP;
                end
            end
`endif
            c_STOP: begin
                if (w_bit_end) begin
                    if (w_pop) begin
                        state_d = c_START;
                        shift_d = mem_q[rd_ptr_q];
                    end else begin
                        state_d = c_IDLE;
                    end
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic. The line value is computed from the next state.
    // This lets the registered output change on the same edge as the state.
    // ------------------------------------------------------------------
    always_comb begin
        uart_tx_d = 1'b1;
        case (state_d)
            c_START:  uart_tx_d = 1'b0;
            c_DATA:   uart_tx_d = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
            c_PARITY: uart_tx_d = ^shift_d;
`endif
            default:  uart_tx_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= c_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            uart_tx_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            uart_tx_q <= uart_tx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Self-checking bench for uart_tx_fifo. A timeline model of the
//                queue and frame predicts every output on every cycle. A line
//                decoder recovers the bytes and checks them against the
//                accepted bytes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic [7:0] tx_data  = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       uart_tx;
    logic       tx_busy;
    logic [2:0] fifo_count;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clock) cyc++;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Reference model. It tracks a queue of bytes and a frame timeline.
    // ------------------------------------------------------------------
    byte unsigned mq[$];
    byte unsigned acc_q[$];
    bit           mact = 1'b0;
    int           mt   = 0;
    bit           mfr[0:10];
    bit           m_push, m_pop;
    byte unsigned m_b;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            mact = 1'b0;
            mt   = 0;
        end else begin
            m_push = tx_valid && (mq.size() < DEPTH);
            m_pop  = (mq.size() > 0) && (!mact || (mt == FL - 1));
            if (mact) begin
                mt++;
                if (mt == FL) mact = 1'b0;
            end
            if (m_pop) begin
                m_b    = mq.pop_front();
                mfr[0] = 1'b0;
                for (int i = 0; i < 8; i++) mfr[i+1] = m_b[i];
`ifdef UART_TX_PARITY_EN
                mfr[9]  = ^m_b;
                mfr[10] = 1'b1;
`else
                mfr[9]  = 1'b1;
`endif
                mact = 1'b1;
                mt   = 0;
            end
            if (m_push) begin
                mq.push_back(tx_data);
                acc_q.push_back(tx_data);
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        chk("uart_tx",    int'(uart_tx),    mact ? int'(mfr[mt / CPB]) : 1);
        chk("fifo_count", int'(fifo_count), mq.size());
        chk("tx_ready",   int'(tx_ready),   int'(mq.size() < DEPTH));
        chk("tx_busy",    int'(tx_busy),    int'(mact || (mq.size() > 0)));
    end

    int pk = 0;
    always @(negedge clock) if (int'(fifo_count) > pk) pk = int'(fifo_count);

    // ------------------------------------------------------------------
    // Line decoder: it samples the middle of each bit.
    // ------------------------------------------------------------------
    byte unsigned rx_q[$];
    bit           rxp_q[$];
    int           st_q[$];
    bit           prev = 1'b1;
    bit           d_ok;
    bit           d_par;
    byte unsigned d_b;

    initial begin
        forever begin
            @(negedge clock);
            if (reset && prev && !uart_tx) begin
                st_q.push_back(cyc);
                d_ok = 1'b1;
                repeat (CPB / 2) begin @(negedge clock); if (!reset) d_ok = 1'b0; end
                if (uart_tx) d_ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(negedge clock); if (!reset) d_ok = 1'b0; end
                    d_b[i] = uart_tx;
                end
                d_par = 1'b0;
`ifdef UART_TX_PARITY_EN
                repeat (CPB) begin @(negedge clock); if (!reset) d_ok = 1'b0; end
                d_par = uart_tx;
`endif
                repeat (CPB) begin @(negedge clock); if (!reset) d_ok = 1'b0; end
                if (!uart_tx) d_ok = 1'b0;
                if (d_ok) begin
                    rx_q.push_back(d_b);
                    rxp_q.push_back(d_par);
                end
            end
            prev = uart_tx;
        end
    end

    byte unsigned exp_q[$];

    task automatic chk_rx(string nm);
        chk({nm, "_n"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk(nm, (i < rx_q.size()) ? int'(rx_q[i]) : -1, int'(exp_q[i]));
    endtask

    task automatic burst();
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clock);
            tx_valid = 1'b1;
            tx_data  = exp_q[i];
        end
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    int n_acc;
    int w;
    int thr;

    initial begin
        // 1. Reset release, idle.
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (1000) @(negedge clock);
        chk("t1_uart_tx", int'(uart_tx), 1);
        chk("t1_ready",   int'(tx_ready), 1);
        chk("t1_busy",    int'(tx_busy), 0);
        chk("t1_count",   int'(fifo_count), 0);

        // 2. Single byte 0x55: latency and frame length.
        rx_q.delete();
        @(negedge clock);
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        @(negedge clock);
        tx_valid = 1'b0;
        chk("t2_line_at_accept", int'(uart_tx), 1);
        @(negedge clock);
        chk("t2_start_low", int'(uart_tx), 0);
        repeat (FL - 1) @(negedge clock);
        chk("t2_busy_last", int'(tx_busy), 1);
        @(negedge clock);
        chk("t2_busy_drop", int'(tx_busy), 0);
        repeat (5) @(negedge clock);
        exp_q = {8'h55};
        chk_rx("t2_rx");

        // 3. Four consecutive pushes, back-to-back frames.
        rx_q.delete();
        pk    = 0;
        exp_q = {8'hA3, 8'h00, 8'hFF, 8'h7E};
        burst();
        repeat (4 * FL + 40) @(negedge clock);
        chk("t3_peak", pk, 3);
        chk_rx("t3_rx");

        // 4. Hold tx_valid while the FIFO fills.
        rx_q.delete();
        exp_q = {8'h3C};
        burst();
        repeat (2) @(negedge clock);
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        n_acc    = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_ready) n_acc++;
            @(negedge clock);
        end
        tx_valid = 1'b0;
        chk("t4_accepted", n_acc, 4);
        chk("t4_count",    int'(fifo_count), 4);
        chk("t4_ready",    int'(tx_ready), 0);
        repeat (5 * FL + 40) @(negedge clock);
        exp_q = {8'h3C, 8'h11, 8'h11, 8'h11, 8'h11};
        chk_rx("t4_rx");

        // 5. Reset mid-frame with bytes queued.
        exp_q = {8'hC3, 8'h12, 8'h34};
        burst();
        repeat (3 * CPB + 4) @(negedge clock);
        chk("t5_count_before", int'(fifo_count), 2);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("t5_uart_tx", int'(uart_tx), 1);
        chk("t5_count",   int'(fifo_count), 0);
        chk("t5_busy",    int'(tx_busy), 0);
        chk("t5_ready",   int'(tx_ready), 1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2 * FL) @(negedge clock);
        rx_q.delete();
        exp_q = {8'h5A};
        burst();
        repeat (FL + 20) @(negedge clock);
        chk_rx("t5_rx");

        // 6. Parity bits and frame spacing.
        rx_q.delete();
        rxp_q.delete();
        st_q.delete();
        exp_q = {8'h07, 8'h03};
        burst();
        repeat (2 * FL + 40) @(negedge clock);
        chk_rx("t6_rx");
        chk("t6_frame_len", (st_q.size() >= 2) ? (st_q[1] - st_q[0]) : -1, FL);
`ifdef UART_TX_PARITY_EN
        chk("t6_par0", (rxp_q.size() > 0) ? int'(rxp_q[0]) : -1, 1);
        chk("t6_par1", (rxp_q.size() > 1) ? int'(rxp_q[1]) : -1, 0);
`endif

        // 7. Randomised traffic with alternating load levels.
        rx_q.delete();
        acc_q.delete();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            thr      = ((i / 500) % 2 == 0) ? 40 : 2;
            tx_valid = ($urandom_range(0, 99) < thr);
            tx_data  = 8'($urandom);
        end
        @(negedge clock);
        tx_valid = 1'b0;
        w = 0;
        while (tx_busy && (w < 2 * (DEPTH + 1) * FL)) begin
            @(negedge clock);
            w++;
        end
        chk("t7_drain", int'(tx_busy), 0);
        repeat (20) @(negedge clock);
        exp_q = acc_q;
        chk_rx("t7_rx");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
